// File: rtl/param_scanner.sv
// Scanner FSM with a saturating fill counter, idle timeout, abort and flush-complete pulse.
// One instance works as the primary or the alternate scanner, selected by RESET_SCANNING.
//
// state     | meaning
// ----------+------------------------------------------------------------
// LOW_PWR   | powered down, waits for goto_stby_in
// STBY      | standby, waits for start_scan_in (abort drains or drops)
// SCANNING  | fill level rises by SCAN_STEP per cycle up to CAPACITY
// IDLE      | full, waits for flush/abort/partner level/timeout
// FLUSHING  | fill level falls by FLUSH_STEP per cycle down to zero
module param_scanner #(
  parameter int WIDTH          = 8,
  parameter int CAPACITY       = 100,
  parameter int RDY_LVL        = 80,
  parameter int HANDOFF_LVL    = 90,
  parameter int PARTNER_LVL    = 50,
  parameter int SCAN_STEP      = 1,
  parameter int FLUSH_STEP     = 1,
  parameter int RESET_SCANNING = 1,
  parameter int IDLE_TIMEOUT   = 0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start_scan_in,
  input  logic             i_goto_stby_in,
  input  logic             i_flush,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_alt_mem_used,
  output logic [WIDTH-1:0] o_mem_used,
  output logic [2:0]       o_state,
  output logic             o_scan_status,
  output logic             o_rdy_flush,
  output logic             o_start_scan_out,
  output logic             o_goto_stby_out,
  output logic             o_flush_done
);

  typedef enum logic [2:0] {
    S_LOW_PWR  = 3'b000,
    S_STBY     = 3'b001,
    S_SCANNING = 3'b010,
    S_IDLE     = 3'b011,
    S_FLUSHING = 3'b100
  } state_t;

  localparam state_t           L_RST_ST   = (RESET_SCANNING != 0) ? S_SCANNING : S_LOW_PWR;
  localparam logic [WIDTH:0]   L_CAP_X    = (WIDTH+1)'(CAPACITY);
  localparam logic [WIDTH:0]   L_SSTEP_X  = (WIDTH+1)'(SCAN_STEP);
  localparam logic [WIDTH:0]   L_FSTEP_X  = (WIDTH+1)'(FLUSH_STEP);
  localparam logic [WIDTH-1:0] L_CAP      = WIDTH'(CAPACITY);
  localparam logic [WIDTH-1:0] L_FSTEP    = WIDTH'(FLUSH_STEP);
  localparam logic [WIDTH-1:0] L_RDY      = WIDTH'(RDY_LVL);
  localparam logic [WIDTH-1:0] L_HAND     = WIDTH'(HANDOFF_LVL);
  localparam logic [WIDTH-1:0] L_PART     = WIDTH'(PARTNER_LVL);
  localparam logic             L_TO_EN    = (IDLE_TIMEOUT != 0);
  localparam logic [15:0]      L_TO_LAST  = 16'(IDLE_TIMEOUT - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_mem_used;
  logic [15:0]      r_idle_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_scan_next;
  logic [WIDTH-1:0] w_flush_next;
  logic             w_full;
  logic             w_empty;
  logic             w_timeout;
  logic             w_scanning;

  // Sum is one bit wider than the level so a large step saturates instead of wrapping.
  assign w_sum        = {1'b0, r_mem_used} + L_SSTEP_X;
  assign w_scan_next  = (w_sum >= L_CAP_X) ? L_CAP : w_sum[WIDTH-1:0];
  assign w_flush_next = ({1'b0, r_mem_used} > L_FSTEP_X) ? (r_mem_used - L_FSTEP) : '0;
  assign w_full       = (r_mem_used == L_CAP);
  assign w_empty      = (r_mem_used == '0);
  assign w_timeout    = L_TO_EN && (r_idle_cnt == L_TO_LAST);
  assign w_scanning   = (r_state == S_SCANNING);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= L_RST_ST;
      r_mem_used <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= (r_state == S_IDLE) ? r_idle_cnt + 16'd1 : 16'd0;
      case (r_state)
        S_LOW_PWR: begin
          if (i_goto_stby_in) r_state <= S_STBY;
        end
        S_STBY: begin
          if (i_abort)              r_state <= w_empty ? S_LOW_PWR : S_FLUSHING;
          else if (i_start_scan_in) r_state <= S_SCANNING;
        end
        S_SCANNING: begin
          r_mem_used <= w_scan_next;
          if (i_abort)                              r_state <= S_FLUSHING;
          else if (w_full)                          r_state <= S_IDLE;
          else if ((r_mem_used >= L_RDY) && i_flush) r_state <= S_FLUSHING;
        end
        S_IDLE: begin
          if (i_abort || i_flush || (i_alt_mem_used >= L_PART) || w_timeout)
            r_state <= S_FLUSHING;
        end
        S_FLUSHING: begin
          r_mem_used <= w_flush_next;
          if (w_empty) r_state <= S_LOW_PWR;
        end
        default: r_state <= S_LOW_PWR;
      endcase
    end
  end

  assign o_mem_used       = r_mem_used;
  assign o_state          = r_state;
  assign o_scan_status    = w_scanning;
  assign o_rdy_flush      = w_scanning && (r_mem_used >= L_RDY);
  assign o_start_scan_out = w_scanning && (r_mem_used >= L_HAND);
  assign o_goto_stby_out  = w_scanning && (r_mem_used >= L_HAND);
  assign o_flush_done     = (r_state == S_FLUSHING) && w_empty;

endmodule

// File: tb/tb_param_scanner.sv
// Bench for param_scanner: three configurations (primary, alternate with step 7/3,
// primary with idle timeout 5) checked each cycle against a rule-level model.
module tb_param_scanner;

  logic       clk = 1'b0;
  logic       rst   [3];
  logic       st_in [3];
  logic       gs_in [3];
  logic       fl    [3];
  logic       ab    [3];
  logic [7:0] alt   [3];
  logic [7:0] mu    [3];
  logic [2:0] sq    [3];
  logic       ss    [3];
  logic       rf    [3];
  logic       so    [3];
  logic       go    [3];
  logic       fd    [3];

  int errors = 0;
  int checks = 0;

  int P_SS [3] = '{1, 7, 1};
  int P_FS [3] = '{1, 3, 1};
  int P_RS [3] = '{1, 0, 1};
  int P_TO [3] = '{0, 0, 5};

  int m_st [3];
  int m_mu [3];
  int m_ic [3];
  bit m_valid [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  param_scanner u0 (
    .i_clk(clk), .i_reset(rst[0]), .i_start_scan_in(st_in[0]), .i_goto_stby_in(gs_in[0]),
    .i_flush(fl[0]), .i_abort(ab[0]), .i_alt_mem_used(alt[0]), .o_mem_used(mu[0]),
    .o_state(sq[0]), .o_scan_status(ss[0]), .o_rdy_flush(rf[0]), .o_start_scan_out(so[0]),
    .o_goto_stby_out(go[0]), .o_flush_done(fd[0]));

  param_scanner #(.RESET_SCANNING(0), .SCAN_STEP(7), .FLUSH_STEP(3)) u1 (
    .i_clk(clk), .i_reset(rst[1]), .i_start_scan_in(st_in[1]), .i_goto_stby_in(gs_in[1]),
    .i_flush(fl[1]), .i_abort(ab[1]), .i_alt_mem_used(alt[1]), .o_mem_used(mu[1]),
    .o_state(sq[1]), .o_scan_status(ss[1]), .o_rdy_flush(rf[1]), .o_start_scan_out(so[1]),
    .o_goto_stby_out(go[1]), .o_flush_done(fd[1]));

  param_scanner #(.IDLE_TIMEOUT(5)) u2 (
    .i_clk(clk), .i_reset(rst[2]), .i_start_scan_in(st_in[2]), .i_goto_stby_in(gs_in[2]),
    .i_flush(fl[2]), .i_abort(ab[2]), .i_alt_mem_used(alt[2]), .o_mem_used(mu[2]),
    .o_state(sq[2]), .o_scan_status(ss[2]), .o_rdy_flush(rf[2]), .o_start_scan_out(so[2]),
    .o_goto_stby_out(go[2]), .o_flush_done(fd[2]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: states 0 low_pwr, 1 stby, 2 scanning, 3 idle, 4 flushing; levels as plain integers.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int nst, nmu;
      if (rst[i]) begin
        m_st[i] = (P_RS[i] != 0) ? 2 : 0;
        m_mu[i] = 0;
        m_ic[i] = 0;
        m_valid[i] = 1'b1;
      end else begin
        nst = m_st[i];
        nmu = m_mu[i];
        case (m_st[i])
          0: if (gs_in[i]) nst = 1;
          1: if (ab[i]) nst = (m_mu[i] > 0) ? 4 : 0;
             else if (st_in[i]) nst = 2;
          2: begin
            nmu = (m_mu[i] + P_SS[i] > 100) ? 100 : m_mu[i] + P_SS[i];
            if (ab[i]) nst = 4;
            else if (m_mu[i] == 100) nst = 3;
            else if (m_mu[i] >= 80 && fl[i]) nst = 4;
          end
          3: if (ab[i] || fl[i] || alt[i] >= 50 || (P_TO[i] != 0 && m_ic[i] == P_TO[i] - 1)) nst = 4;
          4: begin
            nmu = (m_mu[i] - P_FS[i] < 0) ? 0 : m_mu[i] - P_FS[i];
            if (m_mu[i] == 0) nst = 0;
          end
          default: nst = 0;
        endcase
        m_ic[i] = (m_st[i] == 3) ? m_ic[i] + 1 : 0;
        m_st[i] = nst;
        m_mu[i] = nmu;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (m_valid[i]) begin
        int e_sc, e_hi;
        e_sc = (m_st[i] == 2) ? 1 : 0;
        e_hi = (m_st[i] == 2 && m_mu[i] >= 90) ? 1 : 0;
        chk($sformatf("model u%0d {mem,state,scan,rdy,start,stby,done}", i),
            int'({mu[i], sq[i], ss[i], rf[i], so[i], go[i], fd[i]}),
            int'({8'(m_mu[i]), 3'(m_st[i]), 1'(e_sc),
                  1'(m_st[i] == 2 && m_mu[i] >= 80), 1'(e_hi), 1'(e_hi),
                  1'(m_st[i] == 4 && m_mu[i] == 0)}));
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; st_in[i] = 1'b0; gs_in[i] = 1'b0;
      fl[i] = 1'b0; ab[i] = 1'b0; alt[i] = 8'd0;
    end
    @(negedge clk);
    fork
      begin : thr_u0
        chk("u0 reset state", sq[0], 2);
        chk("u0 reset mem", mu[0], 0);
        chk("u0 reset scan_status", ss[0], 1);
        rst[0] = 1'b0;
        wait_n(79); chk("u0 rdy below 80", rf[0], 0);
        wait_n(1);  chk("u0 mem at 80", mu[0], 80); chk("u0 rdy at 80", rf[0], 1);
        wait_n(9);  chk("u0 start_scan at 89", so[0], 0);
        wait_n(1);  chk("u0 start_scan at 90", so[0], 1); chk("u0 goto_stby at 90", go[0], 1);
        wait_n(10); chk("u0 mem full", mu[0], 100); chk("u0 still scanning", sq[0], 2);
        wait_n(1);  chk("u0 idle after full", sq[0], 3); chk("u0 rdy falls", rf[0], 0);
        alt[0] = 8'd49;
        wait_n(3);  chk("u0 alt 49 stays idle", sq[0], 3);
        alt[0] = 8'd50;
        wait_n(1);  chk("u0 alt 50 flushes", sq[0], 4); chk("u0 mem at flush entry", mu[0], 100);
        alt[0] = 8'd0;
        wait_n(100); chk("u0 drained", mu[0], 0); chk("u0 flush_done", fd[0], 1);
        wait_n(1);  chk("u0 low_pwr after flush", sq[0], 0); chk("u0 flush_done one cycle", fd[0], 0);
        rst[0] = 1'b1; wait_n(1); chk("u0 re-reset state", sq[0], 2); rst[0] = 1'b0;
        wait_n(50); fl[0] = 1'b1;
        wait_n(29); chk("u0 flush ignored at 79", sq[0], 2);
        wait_n(1);  chk("u0 still scanning at 80", sq[0], 2);
        wait_n(1);  chk("u0 flush honoured", sq[0], 4); chk("u0 mem at flush", mu[0], 81);
        wait_n(41); chk("u0 mid-flush mem", mu[0], 40);
        fl[0] = 1'b0; rst[0] = 1'b1;
        wait_n(1);  chk("u0 reset mid-flush mem", mu[0], 0); chk("u0 reset mid-flush state", sq[0], 2);
        rst[0] = 1'b0;
        wait_n(85); ab[0] = 1'b1; fl[0] = 1'b1;
        wait_n(1);  chk("u0 abort+flush", sq[0], 4); chk("u0 mem after abort", mu[0], 86);
        ab[0] = 1'b0; fl[0] = 1'b0;
        wait_n(87); chk("u0 low_pwr after abort drain", sq[0], 0);
        gs_in[0] = 1'b1; wait_n(1); gs_in[0] = 1'b0;
        st_in[0] = 1'b1; wait_n(1); st_in[0] = 1'b0;
        wait_n(100); chk("u0 full again", mu[0], 100);
        fl[0] = 1'b1;
        wait_n(1);  chk("u0 full beats flush", sq[0], 3);
        fl[0] = 1'b0;
        wait_n(2);
      end
      begin : thr_u1
        chk("u1 reset state", sq[1], 0);
        chk("u1 reset scan_status", ss[1], 0);
        rst[1] = 1'b0;
        ab[1] = 1'b1; wait_n(1); chk("u1 abort ignored in low_pwr", sq[1], 0); ab[1] = 1'b0;
        gs_in[1] = 1'b1; wait_n(1); chk("u1 stby", sq[1], 1); gs_in[1] = 1'b0;
        ab[1] = 1'b1; wait_n(1); chk("u1 stby abort empty", sq[1], 0); ab[1] = 1'b0;
        gs_in[1] = 1'b1; wait_n(1); gs_in[1] = 1'b0;
        st_in[1] = 1'b1; wait_n(1); chk("u1 scanning", sq[1], 2); st_in[1] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
          wait_n(1); chk($sformatf("u1 step %0d", k), mu[1], 7 * k);
        end
        wait_n(1); chk("u1 saturates", mu[1], 100);
        wait_n(1); chk("u1 idle", sq[1], 3);
        fl[1] = 1'b1; wait_n(1); chk("u1 idle flush", sq[1], 4); fl[1] = 1'b0;
        wait_n(33); chk("u1 step-3 residue", mu[1], 1);
        wait_n(1);  chk("u1 clamps to zero", mu[1], 0); chk("u1 flush_done", fd[1], 1);
        wait_n(1);  chk("u1 low_pwr", sq[1], 0);
      end
      begin : thr_u2
        rst[2] = 1'b0;
        wait_n(101); chk("u2 idle", sq[2], 3);
        wait_n(4);   chk("u2 idle 5th cycle", sq[2], 3);
        wait_n(1);   chk("u2 timeout flush", sq[2], 4);
        wait_n(100); chk("u2 flush_done", fd[2], 1);
        wait_n(1);   chk("u2 low_pwr", sq[2], 0);
      end
    join
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
